// File: rtl/mmu_login_ctrl.sv
// mmu_login_ctrl: key-sequence login session controller for the address-protection MMU
module mmu_login_ctrl #(
  parameter logic [63:0] KEY_ADDR       = 64'h7F00,
  parameter logic [63:0] KEY0           = 64'hA5A5_0001,
  parameter logic [63:0] KEY1           = 64'h5A5A_0002,
  parameter logic [63:0] KEY2           = 64'hC3C3_0003,
  parameter logic [63:0] KEY3           = 64'h3C3C_0004,
  parameter int          SESSION_CYCLES = 256,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  input  logic [1:0]  proc2mem_command,
  input  logic        protected_i,
  input  logic        logout,
  output logic        login,
  output logic        locked,
  output logic [7:0]  fail_cnt,
  output logic [15:0] viol_cnt,
  output logic [15:0] session_left
);
  typedef enum logic [2:0] {IDLE, K1, K2, K3, SESSION, LOCKOUT} state_e;
  localparam logic [15:0] SESS_LEN = 16'(SESSION_CYCLES);
  localparam logic [15:0] LOCK_TOP = 16'(LOCKOUT_CYCLES - 1);
  localparam logic [7:0]  FAIL_MAX = 8'(MAX_FAILS);
  state_e      state_q;
  logic        login_q, locked_q;
  logic [7:0]  fail_q;
  logic [15:0] viol_q, left_q, timer_q;
  logic        key_store, viol;
  logic [63:0] key_exp;
  logic [7:0]  fail_d;
  assign key_store = proc2mem_command == 2'd2 && proc2mem_addr == KEY_ADDR;
  assign viol      = protected_i && (proc2mem_command == 2'd1 || proc2mem_command == 2'd2);
  assign fail_d    = fail_q + 8'd1;
  always_comb key_exp = state_q == K1 ? KEY1 : state_q == K2 ? KEY2 : state_q == K3 ? KEY3 : KEY0;
  assign login        = login_q;
  assign locked       = locked_q;
  assign fail_cnt     = fail_q;
  assign viol_cnt     = viol_q;
  assign session_left = left_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      login_q  <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= '0;
      viol_q   <= '0;
      left_q   <= '0;
      timer_q  <= '0;
    end else begin
      if (viol && viol_q != 16'hFFFF) viol_q <= viol_q + 16'd1;
      case (state_q)
        IDLE, K1, K2, K3:
          if (key_store && proc2mem_data == key_exp) begin
            if (state_q == K3) begin
              state_q <= SESSION;
              login_q <= 1'b1;
              left_q  <= SESS_LEN;
              fail_q  <= '0;
            end else state_q <= state_q == IDLE ? K1 : state_q == K1 ? K2 : K3;
          end else if (key_store || (viol && state_q != IDLE)) begin
            // a mismatched key word or a violation mid-sequence counts as a failed attempt
            fail_q <= fail_d;
            if (fail_d == FAIL_MAX) begin
              state_q  <= LOCKOUT;
              locked_q <= 1'b1;
              timer_q  <= LOCK_TOP;
            end else state_q <= IDLE;
          end
        SESSION:
          if (left_q == 16'd1 || logout || (key_store && proc2mem_data == 64'd0)) begin
            state_q <= IDLE;
            login_q <= 1'b0;
            left_q  <= '0;
          end else left_q <= left_q - 16'd1;
        LOCKOUT:
          if (timer_q == 16'd0) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            fail_q   <= '0;
          end else timer_q <= timer_q - 16'd1;
        default: state_q <= IDLE;
      endcase
    end
endmodule
